// File: rtl/brch_pred_resolve.sv
// Branch resolve + 2-bit predictor table; pred_taken/brch_taken combinational, mispredict 1 cycle after resolve.
// No backpressure: a resolve is accepted on every cycle res_vld is high.
module brch_pred_resolve #(
  parameter int         DATA_W   = 16,
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] lookup_pc,
  output logic              pred_taken,
  input  logic              res_vld,
  input  logic [DATA_W-1:0] res_pc,
  input  logic [2:0]        res_op,
  input  logic [DATA_W-1:0] res_operand,
  input  logic              res_pred,
  output logic              brch_taken,
  output logic              mispredict,
  output logic [STAT_W-1:0] taken_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  localparam logic [2:0] OP_EQZ = 3'b000;
  localparam logic [2:0] OP_NEZ = 3'b001;
  localparam logic [2:0] OP_LTZ = 3'b010;
  localparam logic [2:0] OP_GEZ = 3'b011;
  localparam logic [2:0] OP_GTZ = 3'b100;
  localparam logic [2:0] OP_LEZ = 3'b101;
  localparam logic [2:0] OP_ALW = 3'b110;

  typedef enum logic [1:0] {
    CNT_SN = 2'b00,
    CNT_WN = 2'b01,
    CNT_WT = 2'b10,
    CNT_ST = 2'b11
  } cnt_e;

  logic [1:0]       tbl [ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] res_idx;
  logic             zf;
  logic             sf;
  logic             cond;
  logic [1:0]       res_next;
  logic             mis_now;
  logic             unused_pc_bits;

  // pc[0] is always zero for 2-byte aligned instructions
  assign lookup_idx = lookup_pc[IDX_W:1];
  assign res_idx    = res_pc[IDX_W:1];
  assign unused_pc_bits = ^{lookup_pc[DATA_W-1:IDX_W+1], lookup_pc[0],
                            res_pc[DATA_W-1:IDX_W+1], res_pc[0]};

  // Lookup reads the registered entry, so a same-cycle update is not yet visible
  assign pred_taken = tbl[lookup_idx][1];

  assign zf = (res_operand == '0);
  assign sf = res_operand[DATA_W-1];

  always_comb begin
    cond = 1'b0;
    case (res_op)
      OP_EQZ:  cond = zf;
      OP_NEZ:  cond = ~zf;
      OP_LTZ:  cond = sf;
      OP_GEZ:  cond = ~sf;
      OP_GTZ:  cond = ~sf & ~zf;
      OP_LEZ:  cond = sf | zf;
      OP_ALW:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign brch_taken = res_vld & cond;
  assign mis_now    = res_vld & (res_pred ^ brch_taken);

  always_comb begin
    res_next = tbl[res_idx];
    case (cnt_e'(tbl[res_idx]))
      CNT_SN:  res_next = brch_taken ? CNT_WN : CNT_SN;
      CNT_WN:  res_next = brch_taken ? CNT_WT : CNT_SN;
      CNT_WT:  res_next = brch_taken ? CNT_ST : CNT_WN;
      CNT_ST:  res_next = brch_taken ? CNT_ST : CNT_WT;
      default: res_next = tbl[res_idx];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= CNT_INIT;
      end
    end else if (res_vld) begin
      tbl[res_idx] <= res_next;
    end
  end

  // Statistics saturate so long runs never alias back to small values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict  <= 1'b0;
      taken_cnt   <= '0;
      mispred_cnt <= '0;
    end else begin
      mispredict <= mis_now;
      if (brch_taken && !(&taken_cnt)) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
      if (mis_now && !(&mispred_cnt)) begin
        mispred_cnt <= mispred_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_brch_pred_resolve.sv
// Directed bench for brch_pred_resolve: behavioural model plus hand-computed expectations.
module tb_brch_pred_resolve;

  logic        clk;
  logic        rst;
  logic [15:0] lookup_pc;
  logic        res_vld;
  logic [15:0] res_pc;
  logic [2:0]  res_op;
  logic [15:0] res_operand;
  logic        res_pred;

  logic        pred_taken, brch_taken, mispredict;
  logic [15:0] taken_cnt, mispred_cnt;
  logic        pred_taken4, brch_taken4, mispredict4;
  logic [3:0]  taken_cnt4, mispred_cnt4;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  brch_pred_resolve #(.DATA_W(16), .IDX_W(4), .CNT_INIT(2'b01), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
    .res_vld(res_vld), .res_pc(res_pc), .res_op(res_op), .res_operand(res_operand),
    .res_pred(res_pred), .brch_taken(brch_taken), .mispredict(mispredict),
    .taken_cnt(taken_cnt), .mispred_cnt(mispred_cnt)
  );

  brch_pred_resolve #(.DATA_W(16), .IDX_W(4), .CNT_INIT(2'b01), .STAT_W(4)) dut4 (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_taken(pred_taken4),
    .res_vld(res_vld), .res_pc(res_pc), .res_op(res_op), .res_operand(res_operand),
    .res_pred(res_pred), .brch_taken(brch_taken4), .mispredict(mispredict4),
    .taken_cnt(taken_cnt4), .mispred_cnt(mispred_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: predictor strength as an integer 0..3, counters as unbounded integers
  int mdl [16];
  int m_taken;
  int m_mis_total;
  bit m_mis;

  function automatic bit cond_m(input logic [2:0] op, input logic [15:0] v);
    int signed s;
    s = $signed(v);
    case (op)
      3'd0: return s == 0;
      3'd1: return s != 0;
      3'd2: return s < 0;
      3'd3: return s >= 0;
      3'd4: return s > 0;
      3'd5: return s <= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit t;
    int i;
    if (rst) begin
      for (int k = 0; k < 16; k++) mdl[k] = 1;
      m_taken = 0;
      m_mis_total = 0;
      m_mis = 0;
    end else begin
      t = res_vld && cond_m(res_op, res_operand);
      i = int'(res_pc[4:1]);
      if (res_vld) mdl[i] = t ? sat(mdl[i] + 1, 3) : ((mdl[i] > 0) ? mdl[i] - 1 : 0);
      m_mis = res_vld && (res_pred != t);
      if (t) m_taken++;
      if (m_mis) m_mis_total++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_pred_taken", 32'(pred_taken), 32'(mdl[int'(lookup_pc[4:1])] >= 2));
      chk("m_brch_taken", 32'(brch_taken), 32'(res_vld && cond_m(res_op, res_operand)));
      chk("m_mispredict", 32'(mispredict), 32'(m_mis));
      chk("m_taken_cnt", 32'(taken_cnt), 32'(sat(m_taken, 65535)));
      chk("m_mispred_cnt", 32'(mispred_cnt), 32'(sat(m_mis_total, 65535)));
      chk("m_taken_cnt4", 32'(taken_cnt4), 32'(sat(m_taken, 15)));
      chk("m_mispred_cnt4", 32'(mispred_cnt4), 32'(sat(m_mis_total, 15)));
    end
  end

  task automatic drive(input logic v, input logic [15:0] pc, input logic [2:0] op,
                       input logic [15:0] opnd, input logic p);
    @(posedge clk);
    #1;
    res_vld = v;
    res_pc = pc;
    res_op = op;
    res_operand = opnd;
    res_pred = p;
  endtask

  logic [2:0]  exp_tab [8];
  logic [15:0] opnds [3];
  logic [2:0]  row;
  logic        prev_exp;
  bit          have_prev;
  logic [3:0]  seq_pred;

  initial begin
    rst = 1'b0;
    lookup_pc = '0;
    res_vld = 1'b0;
    res_pc = '0;
    res_op = '0;
    res_operand = '0;
    res_pred = 1'b0;
    // bit k = expected outcome for operand k of {0000, 0005, 8000}
    exp_tab[0] = 3'b001; exp_tab[1] = 3'b110; exp_tab[2] = 3'b100; exp_tab[3] = 3'b011;
    exp_tab[4] = 3'b010; exp_tab[5] = 3'b101; exp_tab[6] = 3'b111; exp_tab[7] = 3'b000;
    opnds[0] = 16'h0000; opnds[1] = 16'h0005; opnds[2] = 16'h8000;

    #1 rst = 1'b1;
    #2;
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    chk("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
    cmp_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Condition matrix
    have_prev = 0;
    for (int op = 0; op < 8; op++) begin
      row = exp_tab[op];
      for (int k = 0; k < 3; k++) begin
        drive(1'b1, 16'h0040, 3'(op), opnds[k], 1'b0);
        #1;
        chk($sformatf("cond_op%0d_k%0d", op, k), 32'(brch_taken), 32'(row[k]));
        if (have_prev) chk("cond_mispredict", 32'(mispredict), 32'(prev_exp));
        prev_exp = row[k];
        have_prev = 1;
      end
    end

    // Saturation walk at idx 3
    lookup_pc = 16'h0006;
    seq_pred = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'h0006, 3'b110, 16'h0, 1'b0);
      #1 chk($sformatf("sat_up_%0d", k), 32'(pred_taken), 32'(seq_pred[k]));
    end
    seq_pred = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'h0006, 3'b111, 16'h0, 1'b0);
      #1 chk($sformatf("sat_dn_%0d", k), 32'(pred_taken), 32'(seq_pred[k]));
    end
    drive(1'b0, 16'h0, 3'b000, 16'h0, 1'b0);
    #1 chk("sat_floor", 32'(pred_taken), 32'd0);

    // Aliasing on idx 1
    drive(1'b1, 16'h0002, 3'b110, 16'h0, 1'b0);
    drive(1'b0, 16'h0, 3'b000, 16'h0, 1'b0);
    lookup_pc = 16'h0003;
    #1 chk("alias_0003", 32'(pred_taken), 32'd1);
    lookup_pc = 16'h0022;
    #1 chk("alias_0022", 32'(pred_taken), 32'd1);
    lookup_pc = 16'h0004;
    #1 chk("alias_0004", 32'(pred_taken), 32'd0);

    // Same-cycle lookup and update at idx 5
    lookup_pc = 16'h000A;
    drive(1'b1, 16'h000A, 3'b110, 16'h0, 1'b0);
    #1 chk("rbw_same", 32'(pred_taken), 32'd0);
    drive(1'b0, 16'h0, 3'b000, 16'h0, 1'b0);
    #1 chk("rbw_next", 32'(pred_taken), 32'd1);

    // Clear counters, then a continuous mispredict stream
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) drive(1'b1, 16'h0010, 3'b001, 16'h0000, 1'b1);
      else            drive(1'b1, 16'h0010, 3'b011, 16'h0001, 1'b0);
      #1;
      if (i > 0) begin
        chk("mis_stream_pulse", 32'(mispredict), 32'd1);
        chk("mis_stream_cnt", 32'(mispred_cnt), 32'(i));
      end
    end
    drive(1'b0, 16'h0, 3'b000, 16'h0, 1'b0);
    #1;
    chk("mis_total", 32'(mispred_cnt), 32'd20);
    chk("mis_total4_sat", 32'(mispred_cnt4), 32'hF);
    chk("taken_total", 32'(taken_cnt), 32'd10);

    // Train idx 5 to strong, then reset between edges
    lookup_pc = 16'h000A;
    for (int k = 0; k < 3; k++) drive(1'b1, 16'h000A, 3'b110, 16'h0, 1'b0);
    drive(1'b0, 16'h0, 3'b000, 16'h0, 1'b0);
    #1;
    chk("pre_rst_pred", 32'(pred_taken), 32'd1);
    chk("pre_rst_taken", 32'(taken_cnt), 32'd13);
    chk("pre_rst_mis", 32'(mispred_cnt), 32'd23);
    @(posedge clk);
    #2;
    rst = 1'b1;
    res_vld = 1'b1; res_pc = 16'h000A; res_op = 3'b110; res_pred = 1'b0;
    #1;
    chk("midrst_pred", 32'(pred_taken), 32'd0);
    chk("midrst_mispredict", 32'(mispredict), 32'd0);
    chk("midrst_taken", 32'(taken_cnt), 32'd0);
    chk("midrst_mis", 32'(mispred_cnt), 32'd0);
    chk("midrst_taken4", 32'(taken_cnt4), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    res_vld = 1'b0;
    #1;
    chk("post_rst_pred", 32'(pred_taken), 32'd0);
    chk("post_rst_taken", 32'(taken_cnt), 32'd0);
    drive(1'b0, 16'h0, 3'b000, 16'h0, 1'b0);
    #1 chk("post_rst_pred2", 32'(pred_taken), 32'd0);

    repeat (2) @(posedge clk);
    #1 cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/brch_pred_resolve.md
Name: brch_pred_resolve

Overview:
Parametrised branch unit. It resolves a branch condition from a full-width operand and supports six conditional modes plus always-taken and never-taken. It holds a direct-mapped table of 2-bit saturating predictors and flags mispredicts. Fetch uses it for lookups. Execute uses it for resolution and table update. The registered mispredict pulse drives the pipeline flush/redirect.

Parameters:
DATA_W, 16, operand and PC width
IDX_W, 4, table index width; 2**IDX_W entries
CNT_INIT, 2'b01, reset value of every predictor entry (weak not-taken)
STAT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
lookup_pc  in  DATA_W  fetch PC
pred_taken  out  1  prediction for lookup_pc (combinational)
res_vld  in  1  resolve request valid this cycle
res_pc  in  DATA_W  PC of the branch being resolved
res_op  in  3  condition select
res_operand  in  DATA_W  register value tested
res_pred  in  1  prediction carried down the pipe with this branch
brch_taken  out  1  resolved outcome (combinational, qualified by res_vld)
mispredict  out  1  registered one-cycle pulse
taken_cnt  out  STAT_W  resolved-taken count
mispred_cnt  out  STAT_W  mispredict count

Behaviour:
- Index: idx = pc[IDX_W:1]. Instructions are 2-byte aligned, so pc[0] is ignored.
- Flags: ZF = (res_operand == 0); SF = res_operand[DATA_W-1].
- Condition select res_op:
  - 000 EQZ: ZF
  - 001 NEZ: ~ZF
  - 010 LTZ: SF
  - 011 GEZ: ~SF
  - 100 GTZ: ~SF & ~ZF
  - 101 LEZ: SF | ZF
  - 110: always taken
  - 111: never taken
- brch_taken = res_vld & cond. It is 0 when res_vld = 0.
- Predictor entry state machine, one per index:
  - States: SN=00, WN=01, WT=10, ST=11.
  - Taken: SN->WN->WT->ST; ST holds.
  - Not-taken: ST->WT->WN->SN; SN holds.
  - pred_taken = entry[lookup_pc idx][1].
- Update: on a rising clk with res_vld = 1, the entry at the res_pc index moves one step per the outcome. No other entry changes.
- Read-before-write: if a lookup and an update hit the same index in the same cycle, pred_taken shows the pre-update value. The new value is visible from the next cycle.
- mispredict is registered: mispredict <= res_vld & (res_pred != brch_taken). It is high for exactly one cycle after the resolving edge. It is 0 when no res_vld was present on the prior edge.
- taken_cnt increments by 1 on each edge where brch_taken = 1.
- mispred_cnt increments by 1 on each edge where res_vld & (res_pred != brch_taken).
- Both statistics counters saturate at all-ones and never wrap.
- Back-to-back res_vld is legal every cycle. Each resolve is independent, so consecutive resolves to the same index update cumulatively.
- Reset, asynchronous, effective immediately mid-operation:
  - All entries = CNT_INIT.
  - mispredict = 0; taken_cnt = 0; mispred_cnt = 0.
  - pred_taken reflects CNT_INIT[1] combinationally.
  - A res_vld asserted during reset causes no update.
- res_op is don't-care when res_vld = 0.
- There is no X-propagation on outputs once reset is applied.

Test Plan:
1. Condition matrix, res_vld=1, res_pred=0: each res_op with res_operand in {16'h0000, 16'h0005, 16'h8000}.
   - EQZ: 1,0,0. NEZ: 0,1,1. LTZ: 0,0,1. GEZ: 1,1,0.
   - GTZ: 0,1,0. LEZ: 1,0,1. op 110: 1,1,1. op 111: 0,0,0.
   - mispredict follows brch_taken one cycle later.
2. Saturation walk at res_pc=16'h0006 (idx 3): 4 taken resolves.
   - Entry goes 01->10->11->11; pred_taken at lookup_pc=16'h0006 reads 0,1,1,1.
   - Then 4 not-taken: entry goes 11->10->01->00->00.
3. Aliasing: update res_pc=16'h0002, then lookup 16'h0003 and 16'h0022 (IDX_W=4).
   - Both alias to idx 1 and see the update.
   - lookup 16'h0004 (idx 2) stays at CNT_INIT.
4. Same-cycle lookup and update at idx 5, entry WN, taken resolve.
   - pred_taken=0 in that cycle; pred_taken=1 the next cycle.
5. Mispredict stream: alternate res_pred=1 with NEZ on operand 0 (actual 0) and res_pred=0 with GEZ on operand 1 (actual 1), every cycle.
   - mispredict is high continuously from cycle 2.
   - mispred_cnt = N after N resolves.
   - Force with STAT_W=4: the counter holds at 4'hF.
6. Assert rst mid-stream with nonzero counters and a trained entry.
   - All outputs and entries return to reset values the same cycle without a clock edge.
   - A resolve held during rst makes no change after release.
